// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | nothing held; OUT_VALID=0, IN_READY=1, OCCUPANCY=0
//   ST_ONE   | main entry valid; OUT_VALID=1, IN_READY=1, OCCUPANCY=1
//   ST_FULL  | main + skid valid; OUT_VALID=1, IN_READY=0, OCCUPANCY=2
module elastic_pipe_reg #(
   parameter int AWL  = 6,
   parameter int DWL  = 32,
   parameter int CWL  = 2,
   parameter int CNTW = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [CWL-1:0]   IN_CTRL,
   input  logic [DWL-1:0]   IN_D1,
   input  logic [DWL-1:0]   IN_D2,
   input  logic [AWL-2:0]   IN_RA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [CWL-1:0]   OUT_CTRL,
   output logic [DWL-1:0]   OUT_D1,
   output logic [DWL-1:0]   OUT_D2,
   output logic [AWL-2:0]   OUT_RA,
   output logic [1:0]       OCCUPANCY,
   output logic [CNTW-1:0]  STALL_CNT
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;

   logic [CWL-1:0]  main_ctrl_q, main_ctrl_d;
   logic [DWL-1:0]  main_d1_q,   main_d1_d;
   logic [DWL-1:0]  main_d2_q,   main_d2_d;
   logic [AWL-2:0]  main_ra_q,   main_ra_d;

   logic [CWL-1:0]  skid_ctrl_q, skid_ctrl_d;
   logic [DWL-1:0]  skid_d1_q,   skid_d1_d;
   logic [DWL-1:0]  skid_d2_q,   skid_d2_d;
   logic [AWL-2:0]  skid_ra_q,   skid_ra_d;

   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

   logic            in_ready;
   logic            out_valid;
   logic            in_fire;
   logic            out_fire;
   logic [1:0]      occupancy;

   // Handshake decode and next-state/payload selection; IN_READY and
   // OUT_VALID come only from state_q so OUT_READY never reaches IN_READY.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_d1_d   = main_d1_q;
      main_d2_d   = main_d2_q;
      main_ra_d   = main_ra_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_d1_d   = skid_d1_q;
      skid_d2_d   = skid_d2_q;
      skid_ra_d   = skid_ra_q;
      stall_cnt_d = stall_cnt_q;
      in_ready    = 1'b1;
      out_valid   = 1'b0;
      occupancy   = 2'd0;

      case (state_q)
         ST_EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
         ST_ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         ST_FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase

      in_fire  = IN_VALID & in_ready;
      out_fire = out_valid & OUT_READY;

      // Counter keeps running through flush; only reset clears it.
      if (out_valid && !OUT_READY && (stall_cnt_q != {CNTW{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNTW'(1);

      if (FLUSH) begin
         // Incoming entry is dropped; a concurrent out_fire has already
         // been sampled downstream, payload is left stale.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = IN_CTRL;
                  main_d1_d   = IN_D1;
                  main_d2_d   = IN_D2;
                  main_ra_d   = IN_RA;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_ctrl_d = IN_CTRL;
                  main_d1_d   = IN_D1;
                  main_d2_d   = IN_D2;
                  main_ra_d   = IN_RA;
               end else if (in_fire) begin
                  state_d     = ST_FULL;
                  skid_ctrl_d = IN_CTRL;
                  skid_d1_d   = IN_D1;
                  skid_d2_d   = IN_D2;
                  skid_ra_d   = IN_RA;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_d1_d   = skid_d1_q;
                  main_d2_d   = skid_d2_q;
                  main_ra_d   = skid_ra_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State, payload and counter registers with async active-high reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_d1_q   <= '0;
         main_d2_q   <= '0;
         main_ra_q   <= '0;
         skid_ctrl_q <= '0;
         skid_d1_q   <= '0;
         skid_d2_q   <= '0;
         skid_ra_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_d1_q   <= main_d1_d;
         main_d2_q   <= main_d2_d;
         main_ra_q   <= main_ra_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_d1_q   <= skid_d1_d;
         skid_d2_q   <= skid_d2_d;
         skid_ra_q   <= skid_ra_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid;
   assign OCCUPANCY = occupancy;
   assign OUT_CTRL  = main_ctrl_q;
   assign OUT_D1    = main_d1_q;
   assign OUT_D2    = main_d2_q;
   assign OUT_RA    = main_ra_q;
   assign STALL_CNT = stall_cnt_q;

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the fixed-payload pipeline stage register. Carries a control field, two data words and a destination register address between pipeline stages.
- Adds an async reset, a valid/ready handshake with a 2-entry skid buffer (full throughput, no combinational OUT_READY->IN_READY path), a synchronous flush for branch/exception squash, and a saturating stall-cycle counter.
- Sits between any two stages of the pipelined datapath, e.g. EX/MEM or MEM/WB.

Parameters:
AWL, 6, address width parameter; register address field is AWL-1 bits
DWL, 32, data word width
CWL, 2, control field width (generalises the two 1-bit control flags)
CNTW, 16, stall counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
FLUSH  in  1  synchronous squash of all held and incoming entries
IN_VALID  in  1  upstream entry valid
IN_READY  out  1  block can accept an entry this cycle
IN_CTRL  in  CWL  control field
IN_D1  in  DWL  data word 1 (e.g. ALU result)
IN_D2  in  DWL  data word 2 (e.g. store data)
IN_RA  in  AWL-1  destination register address
OUT_VALID  out  1  head entry valid
OUT_READY  in  1  downstream accepts head entry
OUT_CTRL  out  CWL  head control field
OUT_D1  out  DWL  head data word 1
OUT_D2  out  DWL  head data word 2
OUT_RA  out  AWL-1  head register address
OCCUPANCY  out  2  entries held, 0..2
STALL_CNT  out  CNTW  saturating count of OUT_VALID & !OUT_READY cycles

Behaviour:
- Storage: main entry (drives OUT_*) and skid entry, each holding CTRL, D1, D2, RA.
- FSM states:
  - EMPTY: OCCUPANCY=0, OUT_VALID=0, IN_READY=1.
  - ONE: OCCUPANCY=1, OUT_VALID=1, IN_READY=1.
  - FULL: OCCUPANCY=2, OUT_VALID=1, IN_READY=0.
- IN_READY, OUT_VALID and OCCUPANCY decode from registered state only.
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Transitions (no FLUSH):
  - EMPTY: in_fire -> ONE, main<=IN. Otherwise hold.
  - ONE, in_fire & out_fire -> ONE, main<=IN.
  - ONE, in_fire & !out_fire -> FULL, skid<=IN, main unchanged.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. IN_VALID is ignored (IN_READY=0).
- Ordering: strict FIFO. The skid entry is always younger than main.
- Latency: 1 cycle from in_fire in EMPTY to OUT_VALID=1. Sustained throughput 1 entry/cycle with OUT_READY held at 1.
- Stable output: main payload must not change while OUT_VALID=1 and OUT_READY=0.
- FLUSH (sync, highest priority):
  - Next state EMPTY; the concurrent in_fire entry is dropped.
  - A concurrent out_fire still completes downstream (the head is sampled that cycle).
  - Payload registers may hold stale values; OUT_VALID=0 next cycle.
- STALL_CNT: +1 on each cycle with OUT_VALID=1 & OUT_READY=0; saturates at 2^CNTW-1 (no wrap). Unaffected by FLUSH; cleared only by RST.
- Reset (async assert, sync-safe deassert):
  - State EMPTY; OUT_VALID=0, IN_READY=1, OCCUPANCY=0.
  - OUT_CTRL=0, OUT_D1=0, OUT_D2=0, OUT_RA=0, skid payload=0, STALL_CNT=0.
  - Reset mid-transfer discards all entries immediately, without waiting for a clock edge.
- Widths: no arithmetic on the payload. Counter increment is CNTW bits with a saturation compare.

Test Plan:
- Reset/pass-through: assert RST mid-cycle with main holding data -> outputs 0 and IN_READY=1 immediately. Release; IN_VALID=1, IN_D1=0x0000_00AA, IN_RA=5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_D1=0xAA, OUT_RA=5.
- Streaming: 8 back-to-back entries D1=1..8, OUT_READY=1 -> outputs 1..8 on consecutive cycles after 1-cycle latency, OCCUPANCY stays 1, STALL_CNT=0.
- Backpressure/skid: send D1=0x10, 0x20, 0x30 with OUT_READY=0 -> 0x10 and 0x20 accepted, IN_READY=0 while 0x30 waits, OCCUPANCY=2, OUT_D1 stays 0x10. Raise OUT_READY -> outputs 0x10, 0x20, 0x30 in order, none lost or duplicated.
- Flush: FULL with 0x10/0x20, assert FLUSH with IN_VALID=1, D1=0x40, OUT_READY=0 -> next cycle OUT_VALID=0, OCCUPANCY=0; 0x40 never appears at the output.
- Flush with handshake: state ONE with 0x50, OUT_READY=1, FLUSH=1 -> 0x50 is consumed that cycle, then EMPTY.
- Stall counter saturation: CNTW=4, hold OUT_VALID=1 and OUT_READY=0 for 20 cycles -> STALL_CNT=15 and holds; FLUSH leaves it at 15; RST clears it to 0.
